// File: rtl/dot_sched_pkg.sv
// Shared types and width helpers for the dot-product sweep scheduler.
package dot_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } dot_sched_state_e;

    // Index width; never zero, so a single-column sweep still has a 1-bit address
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned result_width(input int unsigned vs, input int unsigned jw);
        return $clog2(vs) + jw;
    endfunction

    function automatic int unsigned energy_width(input int unsigned rw, input int unsigned nc);
        return rw + $clog2(nc) + 1;
    endfunction

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dot_product_scheduler_result_fifo.sv
// Synchronous result FIFO with occupancy count; push and pop may occur together.
module result_fifo
    import dot_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              push_data_i,
    input  logic                          pop_i,
    output logic [WIDTH-1:0]              head_o,
    output logic [count_width(DEPTH)-1:0] count_o
);

    localparam int unsigned PTRW = addr_width(DEPTH);
    localparam int unsigned CW   = count_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, rd_ptr_q;

    // Wrapping increment that also handles non power-of-two depths
    function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_o  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (pop_i) rd_ptr_q <= ptr_next(rd_ptr_q);
            if (push_i && !pop_i)      count_o <= count_o + CW'(1);
            else if (!push_i && pop_i) count_o <= count_o - CW'(1);
        end
    end

    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/dot_product_scheduler.sv
// Streams every J column through the sigma.J chain and delivers indexed results.
// Optional signed energy accumulator enabled by DOT_SCHED_ENERGY_EN.
module dot_product_scheduler
    import dot_sched_pkg::*;
#(
    parameter int unsigned VECTOR_SIZE      = 256,
    parameter int unsigned J_ELEMENT_WIDTH  = 4,
    parameter int unsigned INT_RESULT_WIDTH = result_width(VECTOR_SIZE, J_ELEMENT_WIDTH),
    parameter int unsigned NUM_COLS         = VECTOR_SIZE,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   start_i,
    input  logic [VECTOR_SIZE-1:0]                 sigma_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   mem_rd_en_o,
    output logic [addr_width(NUM_COLS)-1:0]        mem_addr_o,
    input  logic [VECTOR_SIZE*J_ELEMENT_WIDTH-1:0] mem_rdata_i,
    output logic [VECTOR_SIZE-1:0]                 dp_sigma_o,
    output logic [VECTOR_SIZE*J_ELEMENT_WIDTH-1:0] dp_j_col_o,
    input  logic [INT_RESULT_WIDTH-1:0]            dp_dot_i,
    output logic                                   res_valid_o,
    input  logic                                   res_ready_i,
    output logic [addr_width(NUM_COLS)-1:0]        res_idx_o,
    output logic [INT_RESULT_WIDTH-1:0]            res_data_o
`ifdef DOT_SCHED_ENERGY_EN
    ,
    output logic signed [energy_width(INT_RESULT_WIDTH, NUM_COLS)-1:0] energy_o
`endif
);

    localparam int unsigned AW = addr_width(NUM_COLS);
    localparam int unsigned CW = count_width(FIFO_DEPTH);
    localparam int unsigned PW = AW + INT_RESULT_WIDTH;
    localparam int unsigned JW = VECTOR_SIZE * J_ELEMENT_WIDTH;

    dot_sched_state_e       state_q, state_d;
    logic [VECTOR_SIZE-1:0] sigma_q;
    logic [AW-1:0]          issue_cnt_q, pop_cnt_q, rd_idx_q, idx1_q;
    logic                   rd_v_q, j_v_q;
    logic [JW-1:0]          j_q;
    logic [CW-1:0]          fifo_count;
    logic [PW-1:0]          fifo_head;
    logic                   start_acc, issue, pop, last_issue, last_pop;

    assign start_acc = (state_q == ST_IDLE) && start_i;
    // Credit check covers every column already issued but not yet in the FIFO
    assign issue      = (state_q == ST_RUN) &&
                        ((32'(fifo_count) + 32'(rd_v_q) + 32'(j_v_q)) < FIFO_DEPTH);
    assign last_issue = issue && (issue_cnt_q == AW'(NUM_COLS - 1));
    assign pop        = res_valid_o && res_ready_i;
    assign last_pop   = pop && (pop_cnt_q == AW'(NUM_COLS - 1));

    always_comb begin
        state_d = state_q;
        done_o  = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_RUN;
            ST_RUN:   if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (last_pop) begin
                    state_d = ST_IDLE;
                    done_o  = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            sigma_q     <= '0;
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
            rd_v_q      <= 1'b0;
            rd_idx_q    <= '0;
            j_v_q       <= 1'b0;
            j_q         <= '0;
            idx1_q      <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                sigma_q     <= sigma_i;
                issue_cnt_q <= '0;
                pop_cnt_q   <= '0;
            end else begin
                if (issue) issue_cnt_q <= issue_cnt_q + AW'(1);
                if (pop)   pop_cnt_q   <= pop_cnt_q + AW'(1);
            end
            // S1 tracks the outstanding read; S2 holds the returned column
            rd_v_q <= issue;
            if (issue) rd_idx_q <= issue_cnt_q;
            j_v_q <= rd_v_q;
            if (rd_v_q) begin
                j_q    <= mem_rdata_i;
                idx1_q <= rd_idx_q;
            end
        end
    end

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PW)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (j_v_q),
        .push_data_i ({idx1_q, dp_dot_i}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign busy_o      = (state_q != ST_IDLE);
    assign mem_rd_en_o = issue;
    assign mem_addr_o  = issue_cnt_q;
    assign dp_sigma_o  = sigma_q;
    assign dp_j_col_o  = j_q;
    assign res_valid_o = (fifo_count != '0);
    assign res_idx_o   = fifo_head[PW-1 -: AW];
    assign res_data_o  = fifo_head[INT_RESULT_WIDTH-1:0];

`ifdef DOT_SCHED_ENERGY_EN
    localparam int unsigned EW = energy_width(INT_RESULT_WIDTH, NUM_COLS);

    logic signed [EW-1:0] energy_q, delta_c;

    // Presenting the in-flight pop makes the final total visible during done_o
    always_comb begin
        delta_c = '0;
        if (pop) begin
            delta_c = sigma_q[res_idx_o] ? EW'($signed(res_data_o))
                                         : -EW'($signed(res_data_o));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        energy_q <= '0;
        else if (start_acc) energy_q <= '0;
        else                energy_q <= energy_q + delta_c;
    end

    assign energy_o = energy_q + delta_c;
`endif

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Scoreboard bench for dot_product_scheduler with a behavioural column memory and chain.
module tb_dot_product_scheduler;

    localparam int unsigned VS = 4;
    localparam int unsigned JW = 4;
    localparam int unsigned RW = 6;
    localparam int unsigned NC = 4;
    localparam int unsigned FD = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned EW = RW + 2 + 1;

    logic             clk, rst_ni, start_i, mem_rd_en_o, busy_o, done_o;
    logic [VS-1:0]    sigma_i, dp_sigma_o;
    logic [AW-1:0]    mem_addr_o, res_idx_o;
    logic [VS*JW-1:0] mem_rdata_i, dp_j_col_o;
    logic [RW-1:0]    dp_dot_i, res_data_o;
    logic             res_valid_o, res_ready_i;
`ifdef DOT_SCHED_ENERGY_EN
    logic signed [EW-1:0] energy_o;
`endif

    dot_product_scheduler #(
        .VECTOR_SIZE(VS), .J_ELEMENT_WIDTH(JW), .INT_RESULT_WIDTH(RW),
        .NUM_COLS(NC), .FIFO_DEPTH(FD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .sigma_i(sigma_i),
        .busy_o(busy_o), .done_o(done_o), .mem_rd_en_o(mem_rd_en_o),
        .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
        .dp_sigma_o(dp_sigma_o), .dp_j_col_o(dp_j_col_o), .dp_dot_i(dp_dot_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_idx_o(res_idx_o), .res_data_o(res_data_o)
`ifdef DOT_SCHED_ENERGY_EN
        , .energy_o(energy_o)
`endif
    );

    typedef struct { int idx; int data; } exp_t;

    exp_t             sb[$];
    logic [VS*JW-1:0] jmem [NC];
    int total = 0, bad = 0, cyc = 0, t0 = 0;
    int first_v, done_cyc, done_cnt, pops, rd_cnt, ready_mode;
    longint exp_energy;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Column memory: one-cycle read latency
    always @(posedge clk) if (mem_rd_en_o) mem_rdata_i <= jmem[mem_addr_o];

    // Combinational chain: sum of +J where sigma=1, -J where sigma=0
    always_comb begin
        int s;
        s = 0;
        for (int k = 0; k < int'(VS); k++)
            s += dp_sigma_o[k] ? int'(dp_j_col_o[k*JW +: JW]) : -int'(dp_j_col_o[k*JW +: JW]);
        dp_dot_i = RW'(s);
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       res_ready_i = 1'b1;
            1:       res_ready_i = 1'b0;
            default: res_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare FIFO head against scoreboard on every valid cycle
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_ni) begin
            if (mem_rd_en_o) rd_cnt++;
            if (res_valid_o) begin
                if (first_v < 0) first_v = cyc - t0 + 1;
                if (sb.size() == 0) begin
                    chk("unexpected_result_idx", res_idx_o, -1);
                end else begin
                    e = sb[0];
                    chk("res_idx", res_idx_o, e.idx);
                    chk("res_data", $signed(res_data_o), e.data);
                    if (res_ready_i) begin
                        void'(sb.pop_front());
                        pops++;
                    end
                end
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc - t0 + 1;
`ifdef DOT_SCHED_ENERGY_EN
                chk("energy", energy_o, exp_energy);
`endif
            end
        end
    end

    function automatic int ref_dot(input logic [VS-1:0] sig, input int c);
        int s;
        s = 0;
        for (int k = 0; k < int'(VS); k++)
            s += sig[k] ? int'(jmem[c][k*JW +: JW]) : -int'(jmem[c][k*JW +: JW]);
        return s;
    endfunction

    task automatic load_const(input int v);
        for (int c = 0; c < int'(NC); c++)
            for (int k = 0; k < int'(VS); k++) jmem[c][k*JW +: JW] = JW'(v);
    endtask

    task automatic load_pattern(input bit rnd);
        for (int c = 0; c < int'(NC); c++)
            for (int k = 0; k < int'(VS); k++)
                jmem[c][k*JW +: JW] = rnd ? JW'($urandom_range(0, 7)) : JW'((c + k) % 8);
    endtask

    task automatic start_sweep(input logic [VS-1:0] sig);
        first_v = -1; done_cyc = -1; done_cnt = 0; pops = 0; rd_cnt = 0; exp_energy = 0;
        for (int c = 0; c < int'(NC); c++) begin
            exp_t e;
            e.idx  = c;
            e.data = ref_dot(sig, c);
            sb.push_back(e);
            exp_energy += sig[c] ? e.data : -e.data;
        end
        @(posedge clk); #1;
        sigma_i = sig;
        start_i = 1'b1;
        @(posedge clk); #1;
        t0      = cyc;
        start_i = 1'b0;
        sigma_i = ~sig;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == 0) chk({name, "_done_timeout"}, 0, 1);
        @(negedge clk); #1;
        chk({name, "_busy_after_done"}, busy_o, 0);
        chk({name, "_pops"}, pops, NC);
        chk({name, "_sb_left"}, sb.size(), 0);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_busy"}, busy_o, 0);
        chk({name, "_done"}, done_o, 0);
        chk({name, "_rd_en"}, mem_rd_en_o, 0);
        chk({name, "_addr"}, mem_addr_o, 0);
        chk({name, "_valid"}, res_valid_o, 0);
        chk({name, "_idx"}, res_idx_o, 0);
        chk({name, "_data"}, res_data_o, 0);
        chk({name, "_sigma"}, dp_sigma_o, 0);
        chk({name, "_jcol"}, dp_j_col_o, 0);
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; sigma_i = '0; ready_mode = 0; res_ready_i = 1'b1;
        first_v = -1; done_cyc = -1; done_cnt = 0; pops = 0; rd_cnt = 0; exp_energy = 0;
        load_const(0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst_ni = 1'b1;

        // Basic sweep: J all 1, sigma all ones
        load_const(1);
        start_sweep(4'b1111);
        wait_done("basic");
        chk("basic_first_valid_cycle", first_v, 4);
        chk("basic_done_cycle", done_cyc, 7);
        chk("basic_done_count", done_cnt, 1);

        // Sign: sigma zero, J all 3 -> -12 each
        load_const(3);
        start_sweep(4'b0000);
        wait_done("sign");
        chk("sign_done_cycle", done_cyc, 7);

        // Back-pressure: ready held low for 10 cycles after the first result
        ready_mode = 1;
        load_const(2);
        start_sweep(4'b0101);
        for (int n = 0; n < 20 && first_v < 0; n++) @(posedge clk);
        chk("bp_first_valid_seen", first_v, 4);
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        chk("bp_issued_while_stalled", rd_cnt, FD);
        chk("bp_rd_en_stalled", mem_rd_en_o, 0);
        chk("bp_pops_while_stalled", pops, 0);
        ready_mode = 0;
        wait_done("bp");

        // Second start inside the sweep must be ignored
        load_pattern(1'b0);
        start_sweep(4'b0011);
        @(posedge clk); #1;
        start_i = 1'b1;
        sigma_i = 4'b1100;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done("restart");
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        chk("restart_done_count", done_cnt, 1);
        chk("restart_busy", busy_o, 0);

        // Mid-sweep reset, then a clean sweep
        load_pattern(1'b0);
        start_sweep(4'b1010);
        repeat (4) @(posedge clk);
        #1;
        rst_ni = 1'b0;
        @(negedge clk); #1;
        check_idle_outputs("midrst");
        sb.delete();
        @(posedge clk); #1;
        rst_ni = 1'b1;
        start_sweep(4'b0110);
        wait_done("after_rst");
        chk("after_rst_first_valid_cycle", first_v, 4);
        chk("after_rst_done_cycle", done_cyc, 7);

        // Random J, sigma and ready
        ready_mode = 2;
        for (int r = 0; r < 3; r++) begin
            load_pattern(1'b1);
            start_sweep(4'($urandom_range(0, 15)));
            wait_done("random");
            chk("random_done_count", done_cnt, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot_product_scheduler.md
# dot_product_scheduler

Sequencer for the combinational sigma·J dot-product chain. On `start_i` it latches a sigma vector, then streams every J column from a 1-cycle-latency column memory through the chain. Each column's `dot_out` is delivered as an indexed result on a valid/ready stream. It owns column addressing, pipeline registers, back-pressure and completion signalling for one local-field sweep.

## Interface
- `VECTOR_SIZE`, 256, sigma bits / elements per J column
- `J_ELEMENT_WIDTH`, 4, bits per J element (unsigned)
- `INT_RESULT_WIDTH`, `$clog2(VECTOR_SIZE)+J_ELEMENT_WIDTH`, signed dot-product width
- `NUM_COLS`, `VECTOR_SIZE`, columns per sweep (≥1)
- `FIFO_DEPTH`, 4, result FIFO entries (≥3)
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i` in 1 clock
- `rst_ni` in 1 asynchronous active-low reset
- `start_i` in 1 start pulse; sampled only in IDLE
- `sigma_i` in `VECTOR_SIZE` spin vector; latched on accepted start
- `busy_o` out 1 sweep in progress
- `done_o` out 1 one-cycle pulse, sweep complete
- `mem_rd_en_o` out 1 column read strobe
- `mem_addr_o` out `$clog2(NUM_COLS)` column index
- `mem_rdata_i` in `VECTOR_SIZE*J_ELEMENT_WIDTH` column data, valid exactly 1 cycle after `mem_rd_en_o`; element k at bits `[k*J_ELEMENT_WIDTH +: J_ELEMENT_WIDTH]`
- `dp_sigma_o` out `VECTOR_SIZE` to chain `sigma`
- `dp_j_col_o` out `VECTOR_SIZE*J_ELEMENT_WIDTH` to chain `J_col` (same packing)
- `dp_dot_i` in `INT_RESULT_WIDTH` from chain `dot_out`, combinational
- `res_valid_o` out 1 result available
- `res_ready_i` in 1 consumer accepts
- `res_idx_o` out `$clog2(NUM_COLS)` column index of result
- `res_data_o` out `INT_RESULT_WIDTH` signed result

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN on `start_i`: latch `sigma_i` into `sigma_q`, clear issue counter and pop counter.
  - RUN→DRAIN after the column with index `NUM_COLS-1` is issued.
  - DRAIN→IDLE when the `NUM_COLS`-th result is popped. `done_o` pulses in that cycle.
- `start_i` outside IDLE is ignored. `sigma_i` changes after start have no effect.
- `dp_sigma_o = sigma_q` at all times.
- Pipeline:
  - S0: `mem_rd_en_o` is asserted with `mem_addr_o` = issue counter.
  - S1: `mem_rdata_i` and the index are registered into `j_q`/`idx1_q` with a valid bit.
  - S2: `dp_j_col_o = j_q`. If S2 is valid, `dp_dot_i` and `idx1_q` are pushed into the result FIFO.
- Issue rule: `mem_rd_en_o` = RUN && (fifo_count + inflight < `FIFO_DEPTH`), where inflight = number of valid S1/S2 stages. The FIFO therefore never overflows and no push is dropped.
- Result stream:
  - `res_*` come from the FIFO head.
  - A pop happens when `res_valid_o && res_ready_i`.
  - Data and index hold stable while valid && !ready.
  - Results are popped in ascending index order 0…`NUM_COLS-1`.
- A push and a pop in the same cycle are both performed; the count is unchanged.
- `busy_o` = state != IDLE. It drops in the cycle after the `done_o` pulse.
- Reset mid-sweep aborts the sweep: FIFO emptied, pipeline valids cleared, state IDLE.
- Reset values: all outputs 0 (`busy_o`, `done_o`, `mem_rd_en_o`, `mem_addr_o`, `res_valid_o`, `res_idx_o`, `res_data_o`, `dp_sigma_o`, `dp_j_col_o`).

## Timing
- `start_i` is sampled at edge 0. The first `mem_rd_en_o` (addr 0) is asserted in cycle 1.
- `j_q` is valid in cycle 3, the push happens at the end of cycle 3, and `res_valid_o` rises in cycle 4. The first result therefore appears 4 cycles after start.
- With `res_ready_i` held high, throughput is one column per cycle.
- `done_o` asserts at cycle `NUM_COLS+3` with no stalls.
- Under stall, issue stops within 1 cycle and resumes the cycle after a pop frees credit.

## Configuration
- Macro `DOT_SCHED_ENERGY_EN`.
- Defined:
  - Adds output `energy_o`, signed, `INT_RESULT_WIDTH+$clog2(NUM_COLS)+1` bits.
  - Cleared on accepted start.
  - On each pop it accumulates `+res_data_o` if `sigma_q[res_idx_o]` else `-res_data_o`.
  - Final value is valid while `done_o` is high, and held until the next start. Reset value 0.
- Undefined: the port and the accumulator are absent; all other behaviour is identical.

## Structure
- Shared package `dot_sched_pkg`:
  - state enum `dot_sched_state_e`
  - width helper functions for address, result and energy widths
- Sub-module `result_fifo`: synchronous FIFO, parameterised depth/width, with count output and simultaneous push/pop.
- All other logic is in this block.

## Test plan
- Basic sweep, `NUM_COLS`=4, `VECTOR_SIZE`=4, J all 1, sigma=4'b1111, ready held high → results idx 0..3 each = 4; first valid at cycle 4; `done_o` at cycle 7.
- Sign: sigma=4'b0000, J all 3 → every result = -12. With the macro defined, `energy_o` = +48.
- Back-pressure: `res_ready_i` low for 10 cycles after first valid → `mem_rd_en_o` stops once count+inflight=`FIFO_DEPTH`; no result lost or duplicated; order preserved.
- Start ignored: a second `start_i` with a different sigma at cycle 2 → no restart, results use the original sigma, exactly one `done_o`.
- Mid-sweep reset: `rst_ni` low at cycle 5 → all outputs 0 next cycle, FIFO empty; a new start gives a clean full sweep from idx 0.
- Random: random J/sigma with random ready → each result equals the reference model Σ±J[k] per column, in order, with `NUM_COLS` pops total.
